paddle_ctrl: RTL and testbench
==============================

# paddle_ctrl

Converts one player's raw up/down push-buttons into the paddle's vertical position for the pong datapath. It synchronises and debounces both buttons, then steps the paddle at a fixed rate while a direction is held, saturating at the screen edges. One instance per player drives the ball block's `pos1`/`pos2` inputs and the paddle renderer.

## Interface
Parameters:
- `ACTIVE_ROWS`, 480, visible rows.
- `PADDLE_HEIGHT`, 64, paddle height in rows.
- `CLKS_PER_MOVE`, 250_000, clocks between paddle steps while a button is held.
- `DEBOUNCE_CLKS`, 50_000, consecutive stable clocks required to accept a button level.
- `STEP`, 2, rows moved per step.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system/pixel clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `btn_up`  in  1  raw, asynchronous, active-high up button.
- `btn_down`  in  1  raw, asynchronous, active-high down button.
- `recenter`  in  1  synchronous one-cycle pulse; returns paddle to centre (round restart).
- `pos`  out  $clog2(ACTIVE_ROWS)  top row of paddle.
- `moving`  out  1  high while in a MOVE state.

## Operation
- Each button passes through a 2-flop synchroniser, then a `debounce` instance.
- Debounce:
  - The counter clears whenever the synchronised input equals the debounced output. Otherwise it increments.
  - When the count reaches DEBOUNCE_CLKS-1, the debounced output flips and the counter clears.
- FSM (`paddle_state_t`): IDLE, MOVE_UP, MOVE_DOWN.
  - up=1, down=0 → MOVE_UP.
  - up=0, down=1 → MOVE_DOWN.
  - Both or neither → IDLE.
  - Direct MOVE_UP↔MOVE_DOWN transitions are allowed.
- Move counter:
  - Clears on any state change and in IDLE.
  - In a MOVE state it counts 0..CLKS_PER_MOVE-1. At CLKS_PER_MOVE-1 it wraps to 0 and issues one step.
- Step arithmetic uses one extra bit to avoid wrap:
  - MOVE_UP: `pos` ← (pos < STEP) ? 0 : pos−STEP.
  - MOVE_DOWN: `pos` ← min(pos+STEP, MAX_POS), where MAX_POS = ACTIVE_ROWS−PADDLE_HEIGHT (416).
- `pos` never leaves [0, MAX_POS]. The state stays MOVE_* at a limit; steps there are no-ops.
- `recenter`:
  - Has highest priority: `pos` ← CENTER_POS = MAX_POS/2 (208) and the move counter clears.
  - The state is unaffected, so a held button keeps moving from centre.
- Reset values: `pos`=208, `moving`=0, state IDLE, synchronisers and debounced levels 0, all counters 0.

## Timing
- Raw button edge → synchronised level after 2 clocks.
- Debounced level flips DEBOUNCE_CLKS clocks after the synchronised level changes, if it stays stable. Any glitch restarts the count.
- State and `moving` register 1 clock after the debounced change.
- First `pos` change occurs CLKS_PER_MOVE clocks after state entry. Later changes come every CLKS_PER_MOVE clocks.
- `pos` and `moving` are registered outputs with no combinational path from inputs.
- `recenter` takes effect on the next edge. If a step is due on the same cycle, recenter wins and the step is discarded.
- Async reset mid-move: outputs return to reset values immediately. Moving resumes only after a full re-debounce.

## Structure
- `pong_pkg`:
  - Shared constants ACTIVE_ROWS, ACTIVE_COLS, PADDLE_HEIGHT, PADDLE_WIDTH, derived MAX_POS/CENTER_POS.
  - `paddle_state_t` enum.
  - The ball block moves to these shared constants as well.
- Sub-module `debounce`: parameter DEBOUNCE_CLKS; ports clk, rst_n, din (already synchronised), dout. It is instantiated twice.

## Test plan
Parameters for all scenarios: DEBOUNCE_CLKS=4, CLKS_PER_MOVE=8, STEP=2.
- **Reset:** assert rst_n=0 mid-run → `pos`=208 and `moving`=0 immediately. After release, no movement with buttons low.
- **Hold up:** hold btn_up → `moving` rises 2+4+1 clocks after press, `pos` reaches 206 at +8 clocks, then decrements by 2 every 8 clocks.
- **Bounce rejection:** btn_down pulses high for 3 clocks then low, repeated → `moving` never asserts and `pos` stays 208.
- **Saturation:**
  - From pos=1, hold up → pos=0 and stays 0.
  - Hold down from 415 → 416 and stays 416 with `moving`=1.
- **Both buttons:** hold both → IDLE, `moving`=0, `pos` unchanged. Releasing up → MOVE_DOWN, first step 8 clocks after entry.
- **Recenter collision:** pulse `recenter` on the same cycle a step is due at pos=100 → `pos`=208 (no step). The next step lands 8 clocks later at 206 while up stays held.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong constants and types used by the paddle and ball blocks.
package pong_pkg;

  // Screen and sprite geometry.
  localparam int ACTIVE_ROWS   = 480;
  localparam int ACTIVE_COLS   = 640;
  localparam int PADDLE_HEIGHT = 64;
  localparam int PADDLE_WIDTH  = 8;

  // Paddle top-row limits derived from the geometry above.
  localparam int MAX_POS    = ACTIVE_ROWS - PADDLE_HEIGHT;
  localparam int CENTER_POS = MAX_POS / 2;

  // Paddle motion state.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2
  } paddle_state_t;

  // Exactly one button held selects a direction; both or neither means stop.
  function automatic paddle_state_t decode_dir(input logic up, input logic down);
    paddle_state_t dir;
    dir = IDLE;
    if (up && !down) begin
      dir = MOVE_UP;
    end else if (!up && down) begin
      dir = MOVE_DOWN;
    end
    return dir;
  endfunction

endpackage

// File: rtl/paddle_ctrl_debounce.sv
// Debouncer for one already-synchronised button level. The output only
// follows the input after it has disagreed with the output for
// DEBOUNCE_CLKS consecutive clocks; any agreement restarts the count.
module debounce #(
  parameter int DEBOUNCE_CLKS = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CLKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;

  // Next-state: clear while stable, count disagreement, flip at the last count.
  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (din == dout_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      dout_d = din;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and accepted level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle controller: synchronises and debounces the up/down buttons, then
// steps the paddle top row at a fixed rate while one direction is held,
// saturating at the screen edges. recenter returns the paddle to centre.
//
// There is no handshake: recenter is a one-cycle pulse sampled on the next
// edge; pos/moving are plain registered levels valid every cycle.
module paddle_ctrl #(
  parameter int ACTIVE_ROWS   = pong_pkg::ACTIVE_ROWS,
  parameter int PADDLE_HEIGHT = pong_pkg::PADDLE_HEIGHT,
  parameter int CLKS_PER_MOVE = 250_000,
  parameter int DEBOUNCE_CLKS = 50_000,
  parameter int STEP          = 2,
  localparam int POS_W        = $clog2(ACTIVE_ROWS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    recenter,
  output logic [POS_W-1:0]        pos,
  output logic                    moving,
  output pong_pkg::paddle_state_t dbg_state
);

  localparam int MAX_POS    = ACTIVE_ROWS - PADDLE_HEIGHT;
  localparam int CENTER_POS = MAX_POS / 2;
  localparam int PW1        = POS_W + 1;
  localparam int MW         = (CLKS_PER_MOVE > 1) ? $clog2(CLKS_PER_MOVE) : 1;

  localparam logic [POS_W-1:0] CENTER   = POS_W'(CENTER_POS);
  localparam logic [PW1-1:0]   MAX_EXT  = PW1'(MAX_POS);
  localparam logic [PW1-1:0]   STEP_EXT = PW1'(STEP);
  localparam logic [MW-1:0]    MOVE_LAST = MW'(CLKS_PER_MOVE - 1);

  // Button synchronisers: bit 1 is the metastability-safe level.
  logic [1:0] up_sync_q, dn_sync_q;
  logic       up_deb, dn_deb;

  pong_pkg::paddle_state_t state_q, state_d;
  logic                    moving_q;
  logic [MW-1:0]           move_cnt_q;
  logic [POS_W-1:0]        pos_q, pos_step_d;

  // Step arithmetic carries one extra bit so neither edge can wrap.
  logic [PW1-1:0] pos_ext, up_val, dn_sum, dn_val;

  // Two-flop synchronisers for the raw asynchronous buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_sync_q <= 2'b00;
      dn_sync_q <= 2'b00;
    end else begin
      up_sync_q <= {up_sync_q[0], btn_up};
      dn_sync_q <= {dn_sync_q[0], btn_down};
    end
  end

  debounce #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_db_up (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (up_sync_q[1]),
    .dout (up_deb)
  );

  debounce #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_db_down (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (dn_sync_q[1]),
    .dout (dn_deb)
  );

  assign pos_ext = {1'b0, pos_q};
  assign up_val  = (pos_ext < STEP_EXT) ? '0 : (pos_ext - STEP_EXT);
  assign dn_sum  = pos_ext + STEP_EXT;
  assign dn_val  = (dn_sum > MAX_EXT) ? MAX_EXT : dn_sum;

  // Next direction and the saturated position one step further along it.
  always_comb begin
    state_d    = pong_pkg::decode_dir(up_deb, dn_deb);
    pos_step_d = pos_q;
    if (state_q == pong_pkg::MOVE_UP) begin
      pos_step_d = POS_W'(up_val);
    end else if (state_q == pong_pkg::MOVE_DOWN) begin
      pos_step_d = POS_W'(dn_val);
    end
  end

  // Motion FSM with registered outputs; recenter overrides any due step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= pong_pkg::IDLE;
      moving_q   <= 1'b0;
      move_cnt_q <= '0;
      pos_q      <= CENTER;
    end else begin
      state_q  <= state_d;
      moving_q <= (state_d != pong_pkg::IDLE);
      if (recenter) begin
        pos_q      <= CENTER;
        move_cnt_q <= '0;
      end else if ((state_d != state_q) || (state_q == pong_pkg::IDLE)) begin
        move_cnt_q <= '0;
      end else if (move_cnt_q == MOVE_LAST) begin
        move_cnt_q <= '0;
        pos_q      <= pos_step_d;
      end else begin
        move_cnt_q <= move_cnt_q + 1'b1;
      end
    end
  end

  assign pos       = pos_q;
  assign moving    = moving_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Testbench for paddle_ctrl. Two instances share the buttons: one with a
// 2-row step and one with a 3-row step, so odd positions (pos=1) and a
// non-exact clamp at the bottom edge are reachable.
module tb_paddle_ctrl;

  localparam int DB      = 4;
  localparam int CPM     = 8;
  localparam int STEP_A  = 2;
  localparam int STEP_B  = 3;
  localparam int MAX_POS = 416;
  localparam int CENTER  = 208;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic recenter = 1'b0;

  always #5 clk = ~clk;

  logic [8:0] pos_a, pos_b;
  logic       moving_a, moving_b;
  pong_pkg::paddle_state_t state_a, state_b;

  paddle_ctrl #(.CLKS_PER_MOVE(CPM), .DEBOUNCE_CLKS(DB), .STEP(STEP_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .recenter(recenter), .pos(pos_a), .moving(moving_a), .dbg_state(state_a)
  );

  paddle_ctrl #(.CLKS_PER_MOVE(CPM), .DEBOUNCE_CLKS(DB), .STEP(STEP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .recenter(recenter), .pos(pos_b), .moving(moving_b), .dbg_state(state_b)
  );

  // ---------------- reference model ----------------
  // Buttons reach the logic two clocks late; a level is accepted after DB
  // consecutive disagreeing samples. Direction: -1 up, +1 down, 0 stop.
  // Steps land every CPM clocks counted from the later of direction entry
  // and the last recenter.
  int   m_cyc = 0;
  int   m_anchor = 0;
  int   m_dir = 0;
  int   m_want;
  logic m_up_hist [2];
  logic m_dn_hist [2];
  logic m_deb_up = 1'b0;
  logic m_deb_dn = 1'b0;
  int   m_run_up = 0;
  int   m_run_dn = 0;
  int   m_pos_a = CENTER;
  int   m_pos_b = CENTER;

  function automatic int clamp_pos(input int p);
    if (p < 0) return 0;
    if (p > MAX_POS) return MAX_POS;
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_anchor = 0; m_dir = 0;
      m_up_hist[0] = 1'b0; m_up_hist[1] = 1'b0;
      m_dn_hist[0] = 1'b0; m_dn_hist[1] = 1'b0;
      m_deb_up = 1'b0; m_deb_dn = 1'b0;
      m_run_up = 0; m_run_dn = 0;
      m_pos_a = CENTER; m_pos_b = CENTER;
    end else begin
      m_cyc++;
      if (m_deb_up && !m_deb_dn) m_want = -1;
      else if (!m_deb_up && m_deb_dn) m_want = 1;
      else m_want = 0;
      if (m_want != m_dir) begin
        m_dir = m_want;
        m_anchor = m_cyc;
      end
      if (recenter) begin
        m_pos_a = CENTER;
        m_pos_b = CENTER;
        m_anchor = m_cyc;
      end else if (m_dir != 0 && m_cyc > m_anchor && ((m_cyc - m_anchor) % CPM) == 0) begin
        m_pos_a = clamp_pos(m_pos_a + m_dir * STEP_A);
        m_pos_b = clamp_pos(m_pos_b + m_dir * STEP_B);
      end
      if (m_up_hist[1] != m_deb_up) begin
        m_run_up++;
        if (m_run_up == DB) begin m_deb_up = ~m_deb_up; m_run_up = 0; end
      end else m_run_up = 0;
      if (m_dn_hist[1] != m_deb_dn) begin
        m_run_dn++;
        if (m_run_dn == DB) begin m_deb_dn = ~m_deb_dn; m_run_dn = 0; end
      end else m_run_dn = 0;
      m_up_hist[1] = m_up_hist[0]; m_up_hist[0] = btn_up;
      m_dn_hist[1] = m_dn_hist[0]; m_dn_hist[0] = btn_down;
    end
  end

  function automatic pong_pkg::paddle_state_t exp_state();
    if (m_dir < 0) return pong_pkg::MOVE_UP;
    if (m_dir > 0) return pong_pkg::MOVE_DOWN;
    return pong_pkg::IDLE;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: wait for the falling edge, then compare everything to the model.
  task automatic tick();
    @(negedge clk);
    check("pos_a", 32'(pos_a), m_pos_a);
    check("pos_b", 32'(pos_b), m_pos_b);
    check("moving_a", 32'(moving_a), 32'(m_dir != 0));
    check("moving_b", 32'(moving_b), 32'(m_dir != 0));
    check("state_a", 32'(state_a), 32'(exp_state()));
  endtask

  task automatic wait_pos_a(input int target, input int budget);
    for (int i = 0; i < budget && pos_a != 9'(target); i++) tick();
  endtask

  task automatic wait_pos_b(input int target, input int budget);
    for (int i = 0; i < budget && pos_b != 9'(target); i++) tick();
  endtask

  // ---------------- directed + random sequence ----------------
  logic saw_moving;
  int   hold;
  int   sel;

  initial begin
    // Reset state.
    repeat (2) tick();
    check("reset_pos", 32'(pos_a), CENTER);
    check("reset_moving", 32'(moving_a), 0);
    rst_n = 1'b1;
    repeat (20) tick();
    check("idle_pos", 32'(pos_a), CENTER);
    check("idle_moving", 32'(moving_a), 0);

    // Hold up: moving after 2+4+1 clocks, first step 8 clocks after entry.
    btn_up = 1'b1;
    repeat (6) tick();
    check("up_moving_pre", 32'(moving_a), 0);
    tick();
    check("up_moving_rise", 32'(moving_a), 1);
    repeat (7) tick();
    check("up_step1_pre", 32'(pos_a), 208);
    tick();
    check("up_step1", 32'(pos_a), 206);
    repeat (8) tick();
    check("up_step2", 32'(pos_a), 204);

    // Recenter on the very edge a step is due at pos=100.
    wait_pos_a(100, 1000);
    check("reach_100", 32'(pos_a), 100);
    repeat (7) tick();
    recenter = 1'b1;
    tick();
    recenter = 1'b0;
    check("recenter_wins_a", 32'(pos_a), 208);
    check("recenter_wins_b", 32'(pos_b), 208);
    repeat (7) tick();
    check("after_recenter_pre", 32'(pos_a), 208);
    tick();
    check("after_recenter_a", 32'(pos_a), 206);
    check("after_recenter_b", 32'(pos_b), 205);

    // Top saturation, including the odd position 1 on the 3-row instance.
    wait_pos_b(1, 1000);
    check("reach_1_b", 32'(pos_b), 1);
    repeat (8) tick();
    check("sat_top_b", 32'(pos_b), 0);
    repeat (400) tick();
    check("sat_top_a", 32'(pos_a), 0);
    check("sat_top_hold_b", 32'(pos_b), 0);
    check("sat_top_moving", 32'(moving_a), 1);

    // Both buttons held stops; releasing up moves down.
    btn_down = 1'b1;
    repeat (6) tick();
    check("both_moving_pre", 32'(moving_a), 1);
    tick();
    check("both_idle", 32'(moving_a), 0);
    repeat (40) tick();
    check("both_pos", 32'(pos_a), 0);
    btn_up = 1'b0;
    repeat (6) tick();
    check("down_moving_pre", 32'(moving_a), 0);
    tick();
    check("down_moving_rise", 32'(moving_a), 1);
    repeat (7) tick();
    check("down_step1_pre", 32'(pos_a), 0);
    tick();
    check("down_step1_a", 32'(pos_a), 2);
    check("down_step1_b", 32'(pos_b), 3);

    // Bottom saturation.
    wait_pos_a(MAX_POS, 2000);
    check("sat_bot_a", 32'(pos_a), MAX_POS);
    check("sat_bot_b", 32'(pos_b), MAX_POS);
    repeat (40) tick();
    check("sat_bot_hold", 32'(pos_a), MAX_POS);
    check("sat_bot_moving", 32'(moving_a), 1);

    // Asynchronous reset mid-move, button still held.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pos_a", 32'(pos_a), CENTER);
    check("async_rst_pos_b", 32'(pos_b), CENTER);
    check("async_rst_moving", 32'(moving_a), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("rst_redebounce_pre", 32'(moving_a), 0);
    tick();
    check("rst_redebounce", 32'(moving_a), 1);
    repeat (8) tick();
    check("rst_resume_a", 32'(pos_a), 210);
    check("rst_resume_b", 32'(pos_b), 211);

    // Bounce rejection: pulses never longer than DB-1 clocks.
    btn_down = 1'b0;
    repeat (12) tick();
    recenter = 1'b1;
    tick();
    recenter = 1'b0;
    check("bounce_start_pos", 32'(pos_a), CENTER);
    saw_moving = 1'b0;
    for (int k = 0; k < 24; k++) begin
      sel = $urandom_range(0, 1);
      if (sel == 0) btn_down = 1'b1; else btn_up = 1'b1;
      hold = $urandom_range(1, DB - 1);
      for (int j = 0; j < hold; j++) begin tick(); saw_moving |= moving_a; end
      btn_down = 1'b0;
      btn_up = 1'b0;
      hold = $urandom_range(1, 3);
      for (int j = 0; j < hold; j++) begin tick(); saw_moving |= moving_a; end
    end
    repeat (10) begin tick(); saw_moving |= moving_a; end
    check("bounce_no_move", 32'(saw_moving), 0);
    check("bounce_pos", 32'(pos_a), CENTER);

    // Random holds with occasional recenter pulses.
    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 3);
      btn_up = sel[0];
      btn_down = sel[1];
      hold = $urandom_range(1, 60);
      for (int j = 0; j < hold; j++) begin
        recenter = ($urandom_range(0, 15) == 0);
        tick();
      end
      recenter = 1'b0;
    end
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
